// File: rtl/control_multiciclo_pkg.sv
// Shared encodings for the multicycle RV32I main controller: FSM states,
// opcodes, extender selects and ALU operation codes.
package control_multiciclo_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWRITE = 4'd4,
    MEMWB    = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Extender select depends only on the opcode, so it is valid in every state.
  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_LW, OP_I, OP_JALR: imm_sel = IMM_I;
      OP_SW:                imm_sel = IMM_S;
      OP_BEQ:               imm_sel = IMM_B;
      OP_JAL:               imm_sel = IMM_J;
      default:              imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/control_multiciclo_alu_decoder.sv
// ALU operation decoder: turns the controller's aluOp plus instruction
// funct fields into the ALU control code.
module alu_decoder
  import control_multiciclo_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] aluControl
);

  always_comb begin
    aluControl = ALU_ADD;
    case (aluOp)
      ALUOP_SUB: aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type sub from addi, whose imm[10] sits in funct7b5
          3'b000:  aluControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  aluControl = ALU_SLT;
          3'b110:  aluControl = ALU_OR;
          3'b111:  aluControl = ALU_AND;
          default: aluControl = ALU_ADD;
        endcase
      end
      default: aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// Moore main controller for the multicycle RV32I core: one state per step,
// memory wait states on memReady, and a sticky TRAP for unsupported opcodes.
module control_multiciclo
  import control_multiciclo_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic       regWrite,
  output logic [1:0] immSrc,
  output logic [2:0] aluControl,
  output logic       illegal
);

  state_t     state_reg;
  state_t     state_next;
  logic [1:0] aluOp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= state_t'(RESET_STATE);
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:    state_next = memReady ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default:      state_next = TRAP;
        endcase
      end
      MEMADR:   state_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_next = memReady ? MEMWB : MEMREAD;
      MEMWRITE: state_next = memReady ? FETCH : MEMWRITE;
      MEMWB:    state_next = FETCH;
      EXECR:    state_next = ALUWB;
      EXECI:    state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BEQ:      state_next = FETCH;
      JAL:      state_next = ALUWB;
      TRAP:     state_next = TRAP;
      default:  state_next = FETCH;
    endcase
  end

  // Outputs are a pure decode so that reset clears them in the same cycle.
  always_comb begin
    pcWrite   = 1'b0;
    adrSrc    = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    resultSrc = 2'b00;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    regWrite  = 1'b0;
    aluOp     = ALUOP_ADD;
    illegal   = 1'b0;
    case (state_reg)
      FETCH: begin
        pcWrite   = memReady;
        irWrite   = memReady;
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
      end
      DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
      end
      MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
      end
      MEMREAD:  adrSrc = 1'b1;
      MEMWRITE: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
      end
      MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
      end
      EXECR: begin
        aluSrcA = 2'b10;
        aluOp   = ALUOP_FUNCT;
      end
      EXECI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        aluOp   = ALUOP_FUNCT;
      end
      ALUWB:    regWrite = 1'b1;
      BEQ: begin
        aluSrcA = 2'b10;
        aluOp   = ALUOP_SUB;
        pcWrite = zero;
      end
      JAL: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b10;
        pcWrite = 1'b1;
      end
      TRAP:     illegal = 1'b1;
      default: ;
    endcase
  end

  assign immSrc = imm_sel(op);

  alu_decoder u_alu_decoder (
    .aluOp      (aluOp),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .aluControl (aluControl)
  );

endmodule

// File: doc/control_multiciclo.md
Name: control_multiciclo

Overview:
- Moore-style main controller for the multicycle RV32I core.
- Sequences fetch, decode, address, memory, execute and writeback steps, one state per cycle.
- Drives the immediate-extender select (immSrc), ALU operand and operation selects, register, PC, IR and memory enables.
- Inserts wait states on a simple memory ready handshake; traps on unsupported opcodes.

Parameters:
- RESET_STATE, 4'd0 (FETCH): state entered on reset.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  7  instruction opcode, from IR[6:0]
- funct3  in  3  instruction funct3, from IR[14:12]
- funct7b5  in  1  IR[30]
- zero  in  1  ALU zero flag
- memReady  in  1  memory completed current access this cycle
- pcWrite  out  1  PC load enable
- adrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- memWrite  out  1  memory write strobe
- irWrite  out  1  IR/oldPC load enable
- resultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- aluSrcA  out  2  00 PC, 01 oldPC, 10 rs1
- aluSrcB  out  2  00 rs2, 01 immExt, 10 constant 4
- regWrite  out  1  register file write enable
- immSrc  out  2  extender select: 00 I, 01 S, 10 B, 11 J
- aluControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  out  1  high while in TRAP

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous, active-high; forces state to FETCH immediately.
- Output decode: all outputs are a combinational decode of state, plus op/funct/zero/memReady where noted below.
- Outputs during reset (FETCH decode):
  - adrSrc=0, aluSrcA=00, aluSrcB=10, aluControl=000, resultSrc=10
  - pcWrite=irWrite=memReady
  - all others 0
- immSrc is decoded from op in every state:
  - 0000011, 0010011, 1100111 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - other -> 00
- ALU decode by aluOp (internal):
  - 00 -> add
  - 01 -> sub
  - 10 -> funct3 decode:
    - 000: sub if op[5]&funct7b5, else add
    - 010: slt
    - 110: or
    - 111: and
    - other: add
- States and transitions:
  - FETCH: adrSrc=0; irWrite=pcWrite=memReady; PC+4 via aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10. Stay while !memReady; else DECODE.
  - DECODE: aluSrcA=01, aluSrcB=01, aluOp=00 (branch target precompute). Next state by op:
    - lw/sw -> MEMADR
    - R (0110011) -> EXECR
    - I-ALU (0010011) -> EXECI
    - beq -> BEQ
    - jal -> JAL
    - else -> TRAP
  - MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00. lw -> MEMREAD; sw -> MEMWRITE.
  - MEMREAD: adrSrc=1, resultSrc=00. Stay until memReady, then MEMWB.
  - MEMWRITE: adrSrc=1, memWrite=1 held until memReady; memReady -> FETCH.
  - MEMWB: resultSrc=01, regWrite=1 -> FETCH.
  - EXECR: aluSrcA=10, aluSrcB=00, aluOp=10 -> ALUWB.
  - EXECI: aluSrcA=10, aluSrcB=01, aluOp=10 -> ALUWB.
  - ALUWB: resultSrc=00, regWrite=1 -> FETCH.
  - BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, pcWrite=zero -> FETCH.
  - JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcWrite=1 -> ALUWB (rd=oldPC+4).
  - TRAP: illegal=1, all enables 0; exits only via reset.
- Boundary conditions:
  - regWrite, memWrite, pcWrite and irWrite are never asserted together except pcWrite+irWrite in FETCH.
  - Reset asserted mid-access drops memWrite in the same cycle (asynchronous).
  - memReady is ignored outside FETCH/MEMREAD/MEMWRITE.
  - Unreachable state encodings go to FETCH.

Decomposition:
- Shared include file:
  - state encodings (4-bit)
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL
  - immSrc codes IMM_I/S/B/J
  - aluControl codes
- One sub-module, alu_decoder: maps aluOp, funct3, funct7b5, op[5] to aluControl (combinational).
- State register and next-state/output decode stay in control_multiciclo.

Test Plan:
- lw (op=0000011), memReady=1 always -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB = 5 cycles; regWrite=1 only in MEMWB with resultSrc=01; immSrc=00 throughout.
- sw (op=0100011), memReady low 3 cycles in MEMWRITE -> memWrite=1 for 4 consecutive cycles, adrSrc=1, immSrc=01; then FETCH.
- beq with zero=1, then zero=0 -> pcWrite=1 in BEQ only when zero=1; aluControl=001; immSrc=10.
- jal (op=1101111) -> immSrc=11; pcWrite=1 in JAL; next ALUWB with regWrite=1; 4 cycles total.
- R-type sub (funct3=000, funct7b5=1) -> aluControl=001 in EXECR; the same with funct7b5=0 -> 000; funct3=110 -> 011.
- op=1111111 -> TRAP, illegal=1, all enables 0 for 10 cycles. Assert reset mid-MEMWRITE -> memWrite=0 immediately, state FETCH.
